// File: rtl/gpio_irq.sv
// gpio_irq: GPIO input conditioning and edge interrupt stage.
// Raw pins are synchronised into clk, optionally debounced, and edge-detected.
// Enabled edges latch into a write-1-to-clear STATUS register that drives a
// single level interrupt gated by CTRL[0].
// Optional feature: define GPIO_IRQ_DEBOUNCE_EN to compile in the sampled
// two-tick debounce filter between the synchroniser and FILTERED.
module gpio_irq #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SAMPLE_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       reg_sel,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic [WIDTH-1:0] pins_in,
    output logic             irq
);

    localparam logic [2:0] SEL_RISE_EN  = 3'b000;
    localparam logic [2:0] SEL_FALL_EN  = 3'b001;
    localparam logic [2:0] SEL_STATUS   = 3'b010;
    localparam logic [2:0] SEL_FILTERED = 3'b011;
    localparam logic [2:0] SEL_CTRL     = 3'b100;

    // Bits of din that map onto a pin; anything above is don't-care.
    localparam logic [31:0] WMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << WIDTH) - 32'd1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] filt_prev_q;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             ctrl_q, ctrl_d;

    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_rise, wr_fall, wr_status, wr_ctrl;
    logic             unused_din;

    assign wdata      = din[WIDTH-1:0];
    assign unused_din = ^(din & ~WMASK);

    assign wr_rise    = we && (reg_sel == SEL_RISE_EN);
    assign wr_fall    = we && (reg_sel == SEL_FALL_EN);
    assign wr_status  = we && (reg_sel == SEL_STATUS);
    assign wr_ctrl    = we && (reg_sel == SEL_CTRL);

    // Edge detection compares the conditioned level with its one-cycle delay.
    assign rise = filt_q & ~filt_prev_q;
    assign fall = ~filt_q & filt_prev_q;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] upd;
    logic             tick;

    // Prescaler tick and two-tick agreement filter: a pin moves FILTERED only
    // when the current sample matches the previous tick's sample.
    always_comb begin
        tick     = (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d  = tick ? '0 : presc_q + 1'b1;
        upd      = ~(sync2_q ^ sample_q) & (sync2_q ^ filt_q);
        filt_d   = filt_q;
        sample_d = sample_q;
        if (tick) begin
            filt_d   = filt_q ^ upd;
            sample_d = sync2_q;
        end
    end

    // Debounce state; reset discards any partial count and history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q  <= '0;
            sample_q <= '0;
        end else begin
            presc_q  <= presc_d;
            sample_q <= sample_d;
        end
    end
`else
    logic [31:0] unused_sample_div;

    assign unused_sample_div = SAMPLE_DIV;

    // Without debounce the synchronised level passes straight through.
    always_comb begin
        filt_d = sync2_q;
    end
`endif

    // Register-file next state; a new edge set wins over a same-cycle clear.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        ctrl_d    = ctrl_q;
        clr_mask  = '0;
        if (wr_rise) begin
            rise_en_d = wdata;
        end
        if (wr_fall) begin
            fall_en_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d = din[0];
        end
        if (wr_status) begin
            clr_mask = wdata;
        end
        status_d = (status_q & ~clr_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Input synchroniser, conditioned level and its delayed copy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
        end else begin
            sync1_q     <= pins_in;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ctrl_q    <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Read mux, zero-extended above WIDTH; unused selects read 0.
    always_comb begin
        dout = '0;
        case (reg_sel)
            SEL_RISE_EN:  dout[WIDTH-1:0] = rise_en_q;
            SEL_FALL_EN:  dout[WIDTH-1:0] = fall_en_q;
            SEL_STATUS:   dout[WIDTH-1:0] = status_q;
            SEL_FILTERED: dout[WIDTH-1:0] = filt_q;
            SEL_CTRL:     dout[0]         = ctrl_q;
            default:      dout            = '0;
        endcase
    end

    assign irq = ctrl_q & (|status_q);

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq.
module tb_gpio_irq;

    localparam int WIDTH      = 16;
    localparam int SAMPLE_DIV = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int SETTLE     = 30;
    localparam int MAX_FLT    = 2 + 2 * SAMPLE_DIV;
`else
    localparam int SETTLE     = 4;
    localparam int MAX_FLT    = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       reg_sel;
    logic             we;
    logic [31:0]      din;
    logic [31:0]      dout;
    logic [WIDTH-1:0] pins_in;
    logic             irq;

    int total = 0;
    int bad   = 0;

    gpio_irq #(.WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk(clk), .reset(reset), .reg_sel(reg_sel), .we(we), .din(din),
        .dout(dout), .pins_in(pins_in), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] data);
        reg_sel = sel;
        din     = data;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
        din     = '0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] val);
        reg_sel = sel;
        #1;
        val = dout;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset   = 1'b0;
        we      = 1'b0;
        reg_sel = '0;
        din     = '0;
        pins_in = 16'hFFFF;
        cyc(2);
        reset = 1'b1;
        for (int s = 0; s < 5; s++) begin
            rd(3'(s), v);
            total++;
            if (v !== 32'h0) begin
                bad++;
                $display("FAIL reset_sel%0d: got %h want %h", s, v, 32'h0);
            end
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        cyc(10);
        rd(3'b011, v);
        total++;
        if (v !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL reset_filtered: got %h want %h", v, 32'h0000_FFFF);
        end
        rd(3'b010, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL reset_status: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_rise;
        logic [31:0] v;
        int n;
        pins_in = 16'hFFFE;
        cyc(SETTLE + 2);
        wr(3'b000, 32'h1);
        wr(3'b100, 32'h1);
        rd(3'b010, v);
        total++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL rise_pre: status %h irq %b want 0 0", v, irq);
        end
        pins_in = 16'hFFFF;
        reg_sel = 3'b011;
        n = 0;
        do begin
            cyc(1);
            n++;
            #1;
        end while (dout[0] !== 1'b1 && n < 40);
`ifdef GPIO_IRQ_DEBOUNCE_EN
        total++;
        if (n > MAX_FLT) begin
            bad++;
            $display("FAIL rise_filt_latency: got %0d edges want <= %0d", n, MAX_FLT);
        end
`else
        total++;
        if (n != MAX_FLT) begin
            bad++;
            $display("FAIL rise_filt_latency: got %0d edges want %0d", n, MAX_FLT);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL rise_irq_early: got %b want 0", irq);
        end
`endif
        cyc(1);
        rd(3'b010, v);
        total++;
        if (v !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL rise_latch: status %h irq %b want 1 1", v, irq);
        end
        wr(3'b010, 32'h1);
        rd(3'b010, v);
        total++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL rise_w1c: status %h irq %b want 0 0", v, irq);
        end
    endtask

    task automatic test_fall_mask;
        logic [31:0] v;
        wr(3'b001, 32'h8000);
        wr(3'b100, 32'h0);
        pins_in = 16'h7FFF;
        cyc(SETTLE);
        rd(3'b010, v);
        total++;
        if (v !== 32'h8000 || irq !== 1'b0) begin
            bad++;
            $display("FAIL fall_masked: status %h irq %b want 8000 0", v, irq);
        end
        wr(3'b100, 32'h1);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL fall_unmask_irq: got %b want 1", irq);
        end
        wr(3'b010, 32'h8000);
        rd(3'b010, v);
        total++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL fall_w1c: status %h irq %b want 0 0", v, irq);
        end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        int n;
        wr(3'b000, 32'h4);
        pins_in = 16'h7FFB;
        cyc(SETTLE);
        rd(3'b010, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL coll_pre: status %h want 0", v);
        end
        pins_in = 16'h7FFF;
        reg_sel = 3'b011;
        n = 0;
        do begin
            cyc(1);
            n++;
            #1;
        end while (dout[2] !== 1'b1 && n < 40);
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL coll_timeout: filtered bit2 %b want 1", dout[2]);
        end
        // FILTERED just rose, so the rise latches on the same edge as this clear.
        wr(3'b010, 32'h4);
        rd(3'b010, v);
        total++;
        if (v !== 32'h4 || irq !== 1'b1) begin
            bad++;
            $display("FAIL coll_set_wins: status %h irq %b want 4 1", v, irq);
        end
        wr(3'b010, 32'h4);
        rd(3'b010, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL coll_clear: status %h want 0", v);
        end
    endtask

    task automatic test_unused_ro;
        logic [31:0] v;
        rd(3'b011, v);
        total++;
        if (v !== 32'h7FFF) begin
            bad++;
            $display("FAIL ro_filtered_before: got %h want %h", v, 32'h7FFF);
        end
        wr(3'b011, 32'hFFFF_FFFF);
        wr(3'b110, 32'hFFFF_FFFF);
        rd(3'b011, v);
        total++;
        if (v !== 32'h7FFF) begin
            bad++;
            $display("FAIL ro_filtered_after: got %h want %h", v, 32'h7FFF);
        end
        for (int s = 5; s < 8; s++) begin
            rd(3'(s), v);
            total++;
            if (v !== 32'h0) begin
                bad++;
                $display("FAIL unused_sel%0d: got %h want 0", s, v);
            end
        end
        rd(3'b000, v);
        total++;
        if (v !== 32'h4) begin
            bad++;
            $display("FAIL ro_rise_en_kept: got %h want 4", v);
        end
        wr(3'b100, 32'hFFFF_FFFF);
        rd(3'b100, v);
        total++;
        if (v !== 32'h1) begin
            bad++;
            $display("FAIL ctrl_readback: got %h want 1", v);
        end
        wr(3'b001, 32'hFFFF_FFFF);
        rd(3'b001, v);
        total++;
        if (v !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL fall_en_zero_ext: got %h want %h", v, 32'h0000_FFFF);
        end
        wr(3'b001, 32'h8000);
    endtask

`ifdef GPIO_IRQ_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] v;
        int n;
        wr(3'b000, 32'h8);
        pins_in = 16'h7FF7;
        cyc(SETTLE);
        wr(3'b010, 32'hFFFF);
        rd(3'b011, v);
        total++;
        if (v !== 32'h7FF7) begin
            bad++;
            $display("FAIL deb_base: filtered %h want %h", v, 32'h7FF7);
        end
        pins_in = 16'h7FFF;
        cyc(3);
        pins_in = 16'h7FF7;
        cyc(SETTLE);
        rd(3'b011, v);
        total++;
        if (v[3] !== 1'b0) begin
            bad++;
            $display("FAIL deb_pulse_filtered: bit3 %b want 0", v[3]);
        end
        rd(3'b010, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL deb_pulse_status: got %h want 0", v);
        end
        pins_in = 16'h7FFF;
        reg_sel = 3'b011;
        n = 0;
        do begin
            cyc(1);
            n++;
            #1;
        end while (dout[3] !== 1'b1 && n < 40);
        total++;
        if (n - 2 > 2 * SAMPLE_DIV) begin
            bad++;
            $display("FAIL deb_hold_latency: got %0d cycles from sync2 want <= %0d", n - 2, 2 * SAMPLE_DIV);
        end
        cyc(12);
        rd(3'b010, v);
        total++;
        if (v !== 32'h8) begin
            bad++;
            $display("FAIL deb_hold_status: got %h want 8", v);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_fall_mask();
        test_collision();
        test_unused_ro();
`ifdef GPIO_IRQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
